// File: rtl/epochtv1_vram_arb_if.sv
// Bus bundle between the epochtv1 requesters, the VRAM arbiter and the external VRAM pins.
// slave = arbiter side, master = requester/VRAM side.
interface epochtv1_vram_arb_if;
  logic        CE;
  logic        VID_ACT;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [12:0] CPU_A;
  logic [7:0]  CPU_DI;
  logic        CPU_RDY;
  logic        CPU_DV;
  logic [7:0]  CPU_DO;
  logic        SPR_REQ;
  logic [11:0] SPR_A;
  logic        SPR_RDY;
  logic        SPR_DV;
  logic [15:0] SPR_D;
  logic        BG_REQ;
  logic [11:0] BG_A;
  logic        BG_RDY;
  logic        BG_DV;
  logic [15:0] BG_D;
  logic [11:0] VAA;
  logic [11:0] VBA;
  logic [7:0]  VAD_I;
  logic [7:0]  VBD_I;
  logic [7:0]  VAD_O;
  logic [7:0]  VBD_O;
  logic        nVARD;
  logic        nVBRD;
  logic        nVAWR;
  logic        nVBWR;

  modport slave (
    input  CE, VID_ACT, CPU_REQ, CPU_WE, CPU_A, CPU_DI, SPR_REQ, SPR_A, BG_REQ, BG_A,
           VAD_I, VBD_I,
    output CPU_RDY, CPU_DV, CPU_DO, SPR_RDY, SPR_DV, SPR_D, BG_RDY, BG_DV, BG_D,
           VAA, VBA, VAD_O, VBD_O, nVARD, nVBRD, nVAWR, nVBWR
  );

  modport master (
    output CE, VID_ACT, CPU_REQ, CPU_WE, CPU_A, CPU_DI, SPR_REQ, SPR_A, BG_REQ, BG_A,
           VAD_I, VBD_I,
    input  CPU_RDY, CPU_DV, CPU_DO, SPR_RDY, SPR_DV, SPR_D, BG_RDY, BG_DV, BG_D,
           VAA, VBA, VAD_O, VBD_O, nVARD, nVBRD, nVAWR, nVBWR
  );
endinterface

// File: rtl/epochtv1_vram_arb.sv
// epochtv1 VRAM arbiter: one access slot per CE period shared by CPU, sprite and background
// fetch; fixed priority that flips with VID_ACT, plus a CPU anti-starvation guard.
module epochtv1_vram_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               CLK,
  input logic               RST,
  epochtv1_vram_arb_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam int unsigned AW = 12;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_CPU = 3'd1;
  localparam logic [2:0] S_RD_SPR = 3'd2;
  localparam logic [2:0] S_RD_BG  = 3'd3;
  localparam logic [2:0] S_WR_A   = 3'd4;
  localparam logic [2:0] S_WR_B   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          lane_q, lane_d;
  logic          nrd_q, nrd_d, nawr_q, nawr_d, nbwr_q, nbwr_d;
  logic          cpu_dv_q, cpu_dv_d, spr_dv_q, spr_dv_d, bg_dv_q, bg_dv_d;
  logic [7:0]    cpu_do_q, cpu_do_d;
  logic [15:0]   spr_d_q, spr_d_d, bg_d_q, bg_d_d;
  logic          cpu_rdy_c, spr_rdy_c, bg_rdy_c, starve_c;

  // Grant selection; the starve override trumps both priority orders
  always_comb begin
    cpu_rdy_c = 1'b0;
    spr_rdy_c = 1'b0;
    bg_rdy_c  = 1'b0;
    starve_c  = (starve_q == CW'(STARVE_MAX)) && bus.CPU_REQ;
    if (starve_c) begin
      cpu_rdy_c = 1'b1;
    end else if (bus.VID_ACT) begin
      if (bus.BG_REQ)       bg_rdy_c  = 1'b1;
      else if (bus.SPR_REQ) spr_rdy_c = 1'b1;
      else if (bus.CPU_REQ) cpu_rdy_c = 1'b1;
    end else begin
      if (bus.CPU_REQ)      cpu_rdy_c = 1'b1;
      else if (bus.BG_REQ)  bg_rdy_c  = 1'b1;
      else if (bus.SPR_REQ) spr_rdy_c = 1'b1;
    end
  end

  // Slot FSM: the slot issued at one CE edge is captured at the next
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lane_d   = lane_q;
    nrd_d    = nrd_q;
    nawr_d   = nawr_q;
    nbwr_d   = nbwr_q;
    cpu_dv_d = cpu_dv_q;
    spr_dv_d = spr_dv_q;
    bg_dv_d  = bg_dv_q;
    cpu_do_d = cpu_do_q;
    spr_d_d  = spr_d_q;
    bg_d_d   = bg_d_q;
    if (bus.CE) begin
      state_d  = S_IDLE;
      nrd_d    = 1'b1;
      nawr_d   = 1'b1;
      nbwr_d   = 1'b1;
      cpu_dv_d = 1'b0;
      spr_dv_d = 1'b0;
      bg_dv_d  = 1'b0;
      case (state_q)
        S_RD_CPU: begin
          cpu_dv_d = 1'b1;
          cpu_do_d = lane_q ? bus.VBD_I : bus.VAD_I;
        end
        S_RD_SPR: begin
          spr_dv_d = 1'b1;
          spr_d_d  = {bus.VBD_I, bus.VAD_I};
        end
        S_RD_BG: begin
          bg_dv_d = 1'b1;
          bg_d_d  = {bus.VBD_I, bus.VAD_I};
        end
        default: ;
      endcase

      if (cpu_rdy_c && bus.CPU_REQ) begin
        addr_d = bus.CPU_A[12:1];
        lane_d = bus.CPU_A[0];
        if (bus.CPU_WE) begin
          wdata_d = bus.CPU_DI;
          state_d = bus.CPU_A[0] ? S_WR_B : S_WR_A;
          nawr_d  = bus.CPU_A[0];
          nbwr_d  = ~bus.CPU_A[0];
        end else begin
          state_d = S_RD_CPU;
          nrd_d   = 1'b0;
        end
      end else if (spr_rdy_c && bus.SPR_REQ) begin
        addr_d  = bus.SPR_A;
        state_d = S_RD_SPR;
        nrd_d   = 1'b0;
      end else if (bg_rdy_c && bus.BG_REQ) begin
        addr_d  = bus.BG_A;
        state_d = S_RD_BG;
        nrd_d   = 1'b0;
      end

      if (!bus.CPU_REQ || cpu_rdy_c) begin
        starve_d = '0;
      end else if (starve_q < CW'(STARVE_MAX)) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lane_q   <= 1'b0;
      nrd_q    <= 1'b1;
      nawr_q   <= 1'b1;
      nbwr_q   <= 1'b1;
      cpu_dv_q <= 1'b0;
      spr_dv_q <= 1'b0;
      bg_dv_q  <= 1'b0;
      cpu_do_q <= '0;
      spr_d_q  <= '0;
      bg_d_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lane_q   <= lane_d;
      nrd_q    <= nrd_d;
      nawr_q   <= nawr_d;
      nbwr_q   <= nbwr_d;
      cpu_dv_q <= cpu_dv_d;
      spr_dv_q <= spr_dv_d;
      bg_dv_q  <= bg_dv_d;
      cpu_do_q <= cpu_do_d;
      spr_d_q  <= spr_d_d;
      bg_d_q   <= bg_d_d;
    end
  end

  assign bus.CPU_RDY = cpu_rdy_c;
  assign bus.SPR_RDY = spr_rdy_c;
  assign bus.BG_RDY  = bg_rdy_c;
  assign bus.CPU_DV  = cpu_dv_q;
  assign bus.CPU_DO  = cpu_do_q;
  assign bus.SPR_DV  = spr_dv_q;
  assign bus.SPR_D   = spr_d_q;
  assign bus.BG_DV   = bg_dv_q;
  assign bus.BG_D    = bg_d_q;
  assign bus.VAA     = addr_q;
  assign bus.VBA     = addr_q;
  assign bus.VAD_O   = wdata_q;
  assign bus.VBD_O   = wdata_q;
  assign bus.nVARD   = nrd_q;
  assign bus.nVBRD   = nrd_q;
  assign bus.nVAWR   = nawr_q;
  assign bus.nVBWR   = nbwr_q;

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Directed bench for epochtv1_vram_arb with a 4K x 16 VRAM model on the pins.
module tb_epochtv1_vram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  epochtv1_vram_arb_if bus();

  epochtv1_vram_arb #(.STARVE_MAX(4)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // VRAM model: lane writes land at the CE edge that closes the write slot
  logic [15:0] mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.CE) begin
      if (!bus.nVAWR) mem[bus.VAA][7:0]  <= bus.VAD_O;
      if (!bus.nVBWR) mem[bus.VBA][15:8] <= bus.VBD_O;
    end
  end

  assign bus.VAD_I = mem[bus.VAA][7:0];
  assign bus.VBD_I = mem[bus.VBA][15:8];

  typedef struct packed {
    logic       vid;
    logic       cpu;
    logic       spr;
    logic       bg;
    logic [2:0] exp_rdy;  // {CPU_RDY, SPR_RDY, BG_RDY}
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // One CE edge followed by an idle clock with CE low; returns 1 time unit after that idle edge
  task automatic ce_edge();
    @(negedge clk);
    bus.CE = 1'b1;
    @(posedge clk);
    #1;
    bus.CE = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.nVAWR, bus.nVBWR, bus.nVARD, bus.nVBRD};
  endfunction

  function automatic logic [2:0] rdys();
    return {bus.CPU_RDY, bus.SPR_RDY, bus.BG_RDY};
  endfunction

  function automatic logic [2:0] dvs();
    return {bus.CPU_DV, bus.SPR_DV, bus.BG_DV};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{vid: 1'b1, cpu: 1'b1, spr: 1'b1, bg: 1'b1, exp_rdy: 3'b001};
    vecs[1] = '{vid: 1'b1, cpu: 1'b1, spr: 1'b1, bg: 1'b0, exp_rdy: 3'b010};
    vecs[2] = '{vid: 1'b1, cpu: 1'b1, spr: 1'b0, bg: 1'b0, exp_rdy: 3'b100};
    vecs[3] = '{vid: 1'b1, cpu: 1'b0, spr: 1'b0, bg: 1'b0, exp_rdy: 3'b000};
    vecs[4] = '{vid: 1'b0, cpu: 1'b1, spr: 1'b1, bg: 1'b1, exp_rdy: 3'b100};
    vecs[5] = '{vid: 1'b0, cpu: 1'b0, spr: 1'b1, bg: 1'b1, exp_rdy: 3'b001};
    vecs[6] = '{vid: 1'b0, cpu: 1'b0, spr: 1'b1, bg: 1'b0, exp_rdy: 3'b010};
    vecs[7] = '{vid: 1'b0, cpu: 1'b0, spr: 1'b0, bg: 1'b0, exp_rdy: 3'b000};

    bus.CE = 1'b0;
    bus.VID_ACT = 1'b1;
    bus.CPU_REQ = 1'b1;
    bus.CPU_WE  = 1'b1;
    bus.CPU_A   = 13'h0003;
    bus.CPU_DI  = 8'h5A;
    bus.SPR_REQ = 1'b1;
    bus.SPR_A   = 12'h100;
    bus.BG_REQ  = 1'b1;
    bus.BG_A    = 12'h200;

    preload(12'h100, 16'hBEEF);
    preload(12'h101, 16'h1234);
    preload(12'h200, 16'hCAFE);
    preload(12'h001, 16'h0000);
    preload(12'h000, 16'h0000);

    // Reset held for 3 CE edges with every requester asking
    for (int i = 0; i < 3; i++) begin
      ce_edge();
      check("reset_strobes", 32'(strobes()), 32'hF);
      check("reset_dv", 32'(dvs()), 32'h0);
    end
    check("reset_vaa", 32'(bus.VAA), 32'h0);
    check("reset_vad_o", 32'(bus.VAD_O), 32'h0);
    check("reset_rdy", 32'(rdys()), 32'b001);

    @(negedge clk);
    rst = 1'b0;
    bus.CPU_REQ = 1'b0;
    bus.SPR_REQ = 1'b0;
    bus.BG_REQ  = 1'b0;
    ce_edge();
    check("idle_strobes", 32'(strobes()), 32'hF);

    // Combinational grant table, no CE edges taken
    for (int i = 0; i < 8; i++) begin
      bus.VID_ACT = vecs[i].vid;
      bus.CPU_REQ = vecs[i].cpu;
      bus.SPR_REQ = vecs[i].spr;
      bus.BG_REQ  = vecs[i].bg;
      #1;
      check($sformatf("grant_vec%0d", i), 32'(rdys()), 32'(vecs[i].exp_rdy));
    end

    // CPU write high lane of word 1, then read it back
    bus.VID_ACT = 1'b0;
    bus.CPU_REQ = 1'b1;
    bus.CPU_WE  = 1'b1;
    bus.CPU_A   = 13'h0003;
    bus.CPU_DI  = 8'h5A;
    bus.SPR_REQ = 1'b0;
    bus.BG_REQ  = 1'b0;
    #1;
    check("wr_rdy", 32'(bus.CPU_RDY), 32'h1);
    ce_edge();
    check("wr_strobes", 32'(strobes()), 32'b1011);
    check("wr_vba", 32'(bus.VBA), 32'h001);
    check("wr_vbd_o", 32'(bus.VBD_O), 32'h5A);
    bus.CPU_WE = 1'b0;
    ce_edge();
    check("rd_strobes", 32'(strobes()), 32'b1100);
    check("wr_no_dv", 32'(dvs()), 32'h0);
    bus.CPU_REQ = 1'b0;
    ce_edge();
    check("rd_dv", 32'(dvs()), 32'b100);
    check("rd_do", 32'(bus.CPU_DO), 32'h5A);
    check("rd_idle_strobes", 32'(strobes()), 32'hF);
    ce_edge();
    check("rd_dv_drop", 32'(dvs()), 32'h0);
    check("rd_do_hold", 32'(bus.CPU_DO), 32'h5A);

    // Priority during active video
    bus.VID_ACT = 1'b1;
    bus.CPU_REQ = 1'b1;
    bus.CPU_WE  = 1'b0;
    bus.SPR_REQ = 1'b1;
    bus.BG_REQ  = 1'b1;
    bus.SPR_A   = 12'h100;
    bus.BG_A    = 12'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("prio_bg_slot%0d", i), 32'(rdys()), 32'b001);
      ce_edge();
      check($sformatf("prio_bg_addr%0d", i), 32'(bus.VAA), 32'h200);
      if (i == 1) begin
        check("prio_bg_dv", 32'(bus.BG_DV), 32'h1);
        check("prio_bg_d", 32'(bus.BG_D), 32'hCAFE);
      end
    end
    bus.BG_REQ = 1'b0;
    #1;
    check("prio_spr_next", 32'(rdys()), 32'b010);
    ce_edge();
    bus.CPU_REQ = 1'b0;
    bus.SPR_REQ = 1'b0;
    ce_edge();
    check("prio_spr_dv", 32'(dvs()), 32'b010);
    check("prio_spr_d", 32'(bus.SPR_D), 32'hBEEF);

    // Starvation: CPU forced in on the 5th CE edge under constant BG demand
    bus.VID_ACT = 1'b1;
    bus.BG_REQ  = 1'b1;
    bus.CPU_REQ = 1'b1;
    bus.CPU_WE  = 1'b0;
    bus.CPU_A   = 13'h0003;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check($sformatf("starve_cpu_rdy_edge%0d", i), 32'(bus.CPU_RDY), (i == 5) ? 32'h1 : 32'h0);
      ce_edge();
    end
    check("starve_cpu_strobes", 32'(strobes()), 32'b1100);
    check("starve_cpu_addr", 32'(bus.VBA), 32'h001);
    check("starve_bg_resume", 32'(rdys()), 32'b001);
    ce_edge();
    check("starve_cpu_dv", 32'(bus.CPU_DV), 32'h1);
    check("starve_cpu_do", 32'(bus.CPU_DO), 32'h5A);
    check("starve_bg_addr", 32'(bus.VAA), 32'h200);
    bus.BG_REQ  = 1'b0;
    bus.CPU_REQ = 1'b0;
    ce_edge();
    ce_edge();

    // Back-to-back sprite reads
    bus.VID_ACT = 1'b0;
    bus.SPR_REQ = 1'b1;
    bus.SPR_A   = 12'h100;
    ce_edge();
    bus.SPR_A   = 12'h101;
    ce_edge();
    check("pipe_dv0", 32'(dvs()), 32'b010);
    check("pipe_d0", 32'(bus.SPR_D), 32'hBEEF);
    bus.SPR_REQ = 1'b0;
    ce_edge();
    check("pipe_dv1", 32'(dvs()), 32'b010);
    check("pipe_d1", 32'(bus.SPR_D), 32'h1234);
    ce_edge();
    check("pipe_dv_end", 32'(dvs()), 32'h0);

    // Reset landing on the capture edge of a BG read
    bus.VID_ACT = 1'b1;
    bus.BG_REQ  = 1'b1;
    bus.BG_A    = 12'h200;
    ce_edge();
    check("rstmid_issue", 32'(strobes()), 32'b1100);
    bus.BG_REQ = 1'b0;
    rst = 1'b1;
    ce_edge();
    check("rstmid_dv", 32'(dvs()), 32'h0);
    check("rstmid_strobes", 32'(strobes()), 32'hF);
    check("rstmid_bg_d", 32'(bus.BG_D), 32'h0);
    check("rstmid_vaa", 32'(bus.VAA), 32'h0);
    rst = 1'b0;
    ce_edge();
    check("rstmid_dv_after", 32'(dvs()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
